vanilla_scoreboard_latency_tracker: RTL

- Parametrised successor of the vanilla core's testbench scoreboard tracker. Tracks any number of long-latency operation classes per register, not a fixed set of flag bits: idiv, remote DRAM/global/group loads, AMOs, fdiv/fsqrt, sequential loads, etc.
- For every pending register it measures issue-to-writeback latency and emits a completion record when the register clears.
- Attributes ID-stage dependency stalls to the class blocking them.
- Sits beside the vanilla core in the testbench, one instance per register file (int, float). Feeds the profiler and trace loggers.

---
 rtl/vanilla_scoreboard_latency_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Vanilla core scoreboard latency tracker.
// Per-register issue-to-writeback latency, class occupancy and stall attribution.
module vanilla_scoreboard_latency_tracker #(
  parameter int els_p = 32,
  parameter int classes_p = 8,
  parameter int clear_ports_p = 2,
  parameter int latency_width_p = 16,
  parameter int count_width_p = 32,
  parameter int ignore_r0_p = 1,
  localparam int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int class_width_lp = (classes_p > 1) ? $clog2(classes_p) : 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic set_v_i,
  input  logic [id_width_lp-1:0] set_id_i,
  input  logic [class_width_lp-1:0] set_class_i,
  input  logic [clear_ports_p-1:0] clear_v_i,
  input  logic [clear_ports_p*id_width_lp-1:0] clear_id_i,
  input  logic stall_v_i,
  input  logic [id_width_lp-1:0] stall_id_i,
  input  logic stats_clear_i,
  output logic [els_p-1:0] pending_o,
  output logic [els_p*class_width_lp-1:0] class_o,
  output logic [classes_p*(id_width_lp+1)-1:0] outstanding_o,
  output logic [clear_ports_p-1:0] done_v_o,
  output logic [clear_ports_p*id_width_lp-1:0] done_id_o,
  output logic [clear_ports_p*class_width_lp-1:0] done_class_o,
  output logic [clear_ports_p*latency_width_p-1:0] done_latency_o,
  output logic [classes_p*count_width_p-1:0] stall_cycles_o,
  output logic error_o,
  output logic [1:0] error_code_o
);

  localparam int ow_lp = id_width_lp + 1;

  logic [els_p-1:0] pending_r;
  logic [class_width_lp-1:0] cls_r [els_p];
  logic [latency_width_p-1:0] lat_r [els_p];
  logic [count_width_p-1:0] stall_r [classes_p];

  logic set_ok;
  logic stall_ok;
  logic [id_width_lp-1:0] clr_id [clear_ports_p];
  logic [clear_ports_p-1:0] clr_ok;
  logic [clear_ports_p-1:0] clr_dup;
  logic [clear_ports_p-1:0] clr_eff;
  logic [els_p-1:0] set_hit;
  logic [els_p-1:0] clr_hit;
  logic err1, err2, err3;

  // qualify events, resolve duplicate clears and classify protocol errors
  always_comb begin
    set_ok = set_v_i && !(ignore_r0_p != 0 && set_id_i == '0);
    stall_ok = stall_v_i && !(ignore_r0_p != 0 && stall_id_i == '0)
      && pending_r[stall_id_i];
    clr_dup = '0;
    clr_eff = '0;
    set_hit = '0;
    clr_hit = '0;
    err2 = 1'b0;
    for (int p = 0; p < clear_ports_p; p++) begin
      clr_id[p] = clear_id_i[p*id_width_lp +: id_width_lp];
      clr_ok[p] = clear_v_i[p]
        && !(ignore_r0_p != 0 && clr_id[p] == '0);
    end
    for (int p = 0; p < clear_ports_p; p++) begin
      for (int q = 0; q < p; q++) begin
        if (clr_ok[p] && clr_ok[q] && clr_id[p] == clr_id[q])
          clr_dup[p] = 1'b1;
      end
    end
    for (int p = 0; p < clear_ports_p; p++) begin
      if (clr_ok[p] && !clr_dup[p]) begin
        if (pending_r[clr_id[p]]) begin
          clr_eff[p] = 1'b1;
          clr_hit[clr_id[p]] = 1'b1;
        end else begin
          err2 = 1'b1;
        end
      end
    end
    if (set_ok)
      set_hit[set_id_i] = 1'b1;
    err1 = set_ok && pending_r[set_id_i] && !clr_hit[set_id_i];
    err3 = |clr_dup;
  end

  // per-register pending, class and saturating latency
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < els_p; r++) begin
      if (!reset_n_i) begin
        pending_r[r] <= 1'b0;
        cls_r[r] <= '0;
        lat_r[r] <= '0;
      end else if (set_hit[r]) begin
        pending_r[r] <= 1'b1;
        cls_r[r] <= set_class_i;
        lat_r[r] <= latency_width_p'(1);
      end else if (clr_hit[r]) begin
        pending_r[r] <= 1'b0;
        cls_r[r] <= '0;
        lat_r[r] <= '0;
      end else if (pending_r[r] && lat_r[r] != '1) begin
        lat_r[r] <= lat_r[r] + latency_width_p'(1);
      end
    end
  end

  // completion records, one cycle after the clear is presented
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      done_v_o <= '0;
      done_id_o <= '0;
      done_class_o <= '0;
      done_latency_o <= '0;
    end else begin
      for (int p = 0; p < clear_ports_p; p++) begin
        done_v_o[p] <= clr_eff[p];
        done_id_o[p*id_width_lp +: id_width_lp] <= clr_id[p];
        done_class_o[p*class_width_lp +: class_width_lp] <=
          cls_r[clr_id[p]];
        done_latency_o[p*latency_width_p +: latency_width_p] <=
          lat_r[clr_id[p]];
      end
    end
  end

  // stall cycles charged to the class of the blocking register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || stats_clear_i) begin
      for (int c = 0; c < classes_p; c++)
        stall_r[c] <= '0;
    end else if (stall_ok && stall_r[cls_r[stall_id_i]] != '1) begin
      stall_r[cls_r[stall_id_i]] <=
        stall_r[cls_r[stall_id_i]] + count_width_p'(1);
    end
  end

  // sticky error flag; the code holds the first error, lowest code first
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_o <= 1'b0;
      error_code_o <= 2'd0;
    end else if (!error_o && (err1 || err2 || err3)) begin
      error_o <= 1'b1;
      priority case (1'b1)
        err1: error_code_o <= 2'd1;
        err2: error_code_o <= 2'd2;
        default: error_code_o <= 2'd3;
      endcase
    end
  end

  // flatten state and count pending registers per class
  always_comb begin
    pending_o = pending_r;
    class_o = '0;
    outstanding_o = '0;
    stall_cycles_o = '0;
    for (int r = 0; r < els_p; r++)
      class_o[r*class_width_lp +: class_width_lp] = cls_r[r];
    for (int c = 0; c < classes_p; c++) begin
      stall_cycles_o[c*count_width_p +: count_width_p] = stall_r[c];
      for (int r = 0; r < els_p; r++) begin
        if (pending_r[r] && cls_r[r] == class_width_lp'(c))
          outstanding_o[c*ow_lp +: ow_lp] =
            outstanding_o[c*ow_lp +: ow_lp] + ow_lp'(1);
      end
    end
  end

endmodule
